// File: rtl/display_counter_pkg.sv
// Shared definitions for the display counter and the HEX digit decoders.
//   state_t   : run/hold FSM encoding (S_RUN=0, S_HOLD=1)
//   SEG_*     : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   seg_of()  : 4-bit value -> segment pattern
package display_counter_pkg;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            4'hF:    s = SEG_F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_decoder.sv
// Combinational 4-bit to active-low 7-segment decoder, one per HEX digit.
//   digit : value to show (0..15)
//   hex   : segments {g,f,e,d,c,b,a}, 0 = lit
module hex_decoder
    import display_counter_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] hex
);

    always_comb hex = seg_of(digit);

endmodule

// File: rtl/display_counter.sv
// Counts rate-divider enable pulses modulo MAX+1 and drives one HEX digit.
// A push button toggles between RUN (counting) and HOLD (frozen count).
//   clock    : board clock
//   clear_b  : async active-low reset
//   enable   : count strobe, one count per high cycle while running
//   par_load : synchronous load of load_val (clamped to MAX), overrides counting
//   load_val : value to load
//   up_down  : 1 = up, 0 = down
//   pause_n  : raw active-low button, asynchronous to clock
//   q        : current count
//   carry    : high for one cycle alongside the wrapped q value
//   running  : 1 in RUN, 0 in HOLD
//   hex      : active-low segments for q
module display_counter
    import display_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clock,
    input  logic             clear_b,
    input  logic             enable,
    input  logic             par_load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_down,
    input  logic             pause_n,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             running,
    output logic [6:0]       hex
);

    if (MAX >= (1 << WIDTH)) begin : g_bad_max
        $error("display_counter: MAX must be less than 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    // Button synchroniser plus one edge-detect flop; all idle at released (1).
    logic sync_1, sync_2, btn_prev;
    logic press;

    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            sync_1   <= 1'b1;
            sync_2   <= 1'b1;
            btn_prev <= 1'b1;
        end else begin
            sync_1   <= pause_n;
            sync_2   <= sync_1;
            btn_prev <= sync_2;
        end
    end

    // High only on the cycle the synchronised button goes released->pressed,
    // so a held button toggles once.
    assign press = btn_prev & ~sync_2;

    state_t state, state_nxt;

    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) state <= S_RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (press) state_nxt = S_HOLD;
            S_HOLD:  if (press) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    assign running = (state == S_RUN);

    // Counter uses the current (pre-toggle) state, so a press in the same
    // cycle as enable still lets that count through.
    always_ff @(posedge clock or negedge clear_b) begin
        if (!clear_b) begin
            q     <= '0;
            carry <= 1'b0;
        end else if (par_load) begin
            q     <= (load_val > MAX_V) ? MAX_V : load_val;
            carry <= 1'b0;
        end else if (running && enable) begin
            if (up_down) begin
                if (q == MAX_V) begin
                    q     <= '0;
                    carry <= 1'b1;
                end else begin
                    q     <= q + WIDTH'(1);
                    carry <= 1'b0;
                end
            end else begin
                if (q == '0) begin
                    q     <= MAX_V;
                    carry <= 1'b1;
                end else begin
                    q     <= q - WIDTH'(1);
                    carry <= 1'b0;
                end
            end
        end else begin
            carry <= 1'b0;
        end
    end

    hex_decoder u_hex (
        .digit (4'(q)),
        .hex   (hex)
    );

endmodule
